hazard_scoreboard: RTL and testbench

Parametrised hazard detection unit for the in-order pipeline. It combines the single-cycle load-use interlock with a register scoreboard for variable-latency operations such as a multi-cycle mul/div or memory loads with wait states. It sits beside the ID stage. Its outputs are a stall for IF/ID and a bubble-insert (`flush`) for the ID/EX register. It also counts stall cycles for performance monitoring.

---
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard detection beside ID: load-use interlock plus a busy-bit scoreboard for
// variable-latency ops. Drives stall (IF/ID hold) and flush (ID/EX bubble).
module hazard_scoreboard #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned RW      = $clog2(NREGS),
  localparam int unsigned PW      = $clog2(MAX_PEND + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RW-1:0]    rs1,
  input  logic [RW-1:0]    rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_long,
  input  logic [RW-1:0]    rd_frm_ex,
  input  logic [1:0]       wb_sel_frm_ex,
  input  logic             lwb_valid,
  input  logic [RW-1:0]    lwb_rd,
  output logic             stall,
  output logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [PW-1:0]    pend_cnt,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [NREGS-1:0] r_busy;
  logic [PW-1:0]    r_pend;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_ex_load;
  logic             w_lu1, w_lu2;
  logic             w_raw1, w_raw2;
  logic             w_waw;
  logic             w_struct;
  logic             w_hazard;
  logic             w_stall;
  logic             w_issue;
  logic             w_inc, w_dec;
  logic [NREGS-1:0] w_busy_nxt;

  // A same-cycle writeback of the register in question lifts the hazard,
  // since the register file is write-first.
  always_comb begin
    w_ex_load = (wb_sel_frm_ex == 2'b01) && (rd_frm_ex != '0);
    w_lu1     = w_ex_load && rs1_used && (rs1 == rd_frm_ex);
    w_lu2     = w_ex_load && rs2_used && (rs2 == rd_frm_ex);
    w_raw1    = rs1_used && (rs1 != '0) && r_busy[rs1] &&
                !(lwb_valid && (lwb_rd == rs1));
    w_raw2    = rs2_used && (rs2 != '0) && r_busy[rs2] &&
                !(lwb_valid && (lwb_rd == rs2));
    w_waw     = (id_rd != '0) && r_busy[id_rd] &&
                !(lwb_valid && (lwb_rd == id_rd));
    w_struct  = id_long && (r_pend == PW'(MAX_PEND)) && !lwb_valid;
    w_hazard  = id_valid && (w_lu1 || w_lu2 || w_raw1 || w_raw2 || w_waw || w_struct);
    w_stall   = w_hazard && !rst;
  end

  always_comb begin
    w_issue = id_valid && !w_stall;
    w_inc   = w_issue && id_long;
    w_dec   = lwb_valid && (r_pend != '0);
  end

  // Clear first, then set, so an issue to X wins over a writeback of X.
  always_comb begin
    w_busy_nxt = r_busy;
    if (lwb_valid && (lwb_rd != '0))
      w_busy_nxt[lwb_rd] = 1'b0;
    if (w_inc && (id_rd != '0))
      w_busy_nxt[id_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= '0;
      r_pend      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      case ({w_inc, w_dec})
        2'b10:   r_pend <= r_pend + 1'b1;
        2'b01:   r_pend <= r_pend - 1'b1;
        default: r_pend <= r_pend;
      endcase
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      assert (!lwb_valid || ((r_pend != '0) && ((lwb_rd == '0) || r_busy[lwb_rd])))
        else $error("hazard_scoreboard: writeback to idle register %0d (pend_cnt=%0d)",
                    lwb_rd, r_pend);
    end
  end

  assign stall        = w_stall;
  assign flush        = w_stall;
  assign busy         = r_busy;
  assign pend_cnt     = r_pend;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, long RAW, structural, WAW,
// unused sources, reset under hazard and stall-counter saturation.
module tb_hazard_scoreboard;

  localparam int unsigned NREGS = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned PW    = 3;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [RW-1:0]    rs1, rs2;
  logic             rs1_used, rs2_used;
  logic [RW-1:0]    id_rd;
  logic             id_long;
  logic [RW-1:0]    rd_frm_ex;
  logic [1:0]       wb_sel_frm_ex;
  logic             lwb_valid;
  logic [RW-1:0]    lwb_rd;
  logic             stall, flush;
  logic [NREGS-1:0] busy;
  logic [PW-1:0]    pend_cnt;
  logic [CNT_W-1:0] stall_cycles;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  hazard_scoreboard #(.NREGS(NREGS), .MAX_PEND(4), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .id_rd(id_rd), .id_long(id_long),
    .rd_frm_ex(rd_frm_ex), .wb_sel_frm_ex(wb_sel_frm_ex), .lwb_valid(lwb_valid),
    .lwb_rd(lwb_rd), .stall(stall), .flush(flush), .busy(busy),
    .pend_cnt(pend_cnt), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; rs1 = '0; rs2 = '0; rs1_used = 0; rs2_used = 0;
    id_rd = '0; id_long = 0; rd_frm_ex = '0; wb_sel_frm_ex = 2'b00;
    lwb_valid = 0; lwb_rd = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic issue_long(input logic [RW-1:0] rd);
    idle();
    id_valid = 1; id_long = 1; id_rd = rd;
    #1 chk("issue_no_stall", 32'(stall), 32'd0);
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    #1 chk("rst_stall", 32'(stall), 32'd0);
    rst = 0;
    #1;
    chk("rst_busy", busy, 32'h0);
    chk("rst_pend", 32'(pend_cnt), 32'd0);
    chk("rst_scnt", 32'(stall_cycles), 32'd0);

    // load-use: one stall, then the bubble appears in EX
    id_valid = 1; rs1 = 5; rs1_used = 1; wb_sel_frm_ex = 2'b01; rd_frm_ex = 5;
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_flush", 32'(flush), 32'd1);
    tick();
    wb_sel_frm_ex = 2'b00; rd_frm_ex = 0;
    #1 chk("lu_release", 32'(stall), 32'd0);
    chk("lu_scnt", 32'(stall_cycles), 32'd1);
    wb_sel_frm_ex = 2'b01; rd_frm_ex = 0;
    #1 chk("lu_x0", 32'(stall), 32'd0);
    rs1_used = 0; rs2 = 12; rs2_used = 1; rd_frm_ex = 12;
    #1 chk("lu_rs2", 32'(stall), 32'd1);

    // long RAW on x7, writeback after 5 stall cycles
    do_reset();
    issue_long(7);
    chk("raw_busy", busy, 32'h0000_0080);
    chk("raw_pend", 32'(pend_cnt), 32'd1);
    id_valid = 1; rs1 = 7; rs1_used = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("raw_stall", 32'(stall), 32'd1);
      tick();
    end
    lwb_valid = 1; lwb_rd = 7;
    #1 chk("raw_wb_cycle", 32'(stall), 32'd0);
    tick();
    idle();
    #1;
    chk("raw_busy_clr", busy, 32'h0);
    chk("raw_pend_clr", 32'(pend_cnt), 32'd0);
    chk("raw_scnt", 32'(stall_cycles), 32'd5);

    // structural limit at MAX_PEND=4
    do_reset();
    for (int r = 1; r <= 4; r++) issue_long(RW'(r));
    chk("st_busy", busy, 32'h0000_001E);
    chk("st_pend", 32'(pend_cnt), 32'd4);
    id_valid = 1; id_long = 1; id_rd = 10;
    #1 chk("st_stall", 32'(stall), 32'd1);
    tick();
    chk("st_pend_hold", 32'(pend_cnt), 32'd4);
    chk("st_busy_hold", busy, 32'h0000_001E);
    lwb_valid = 1; lwb_rd = 1;
    #1 chk("st_wb_release", 32'(stall), 32'd0);
    tick();
    idle();
    #1;
    chk("st_pend_same", 32'(pend_cnt), 32'd4);
    chk("st_busy_swap", busy, 32'h0000_041C);

    // WAW and set-over-clear on x9, then long op to x0
    do_reset();
    issue_long(9);
    id_valid = 1; id_long = 1; id_rd = 9;
    #1 chk("waw_stall", 32'(stall), 32'd1);
    tick();
    lwb_valid = 1; lwb_rd = 9;
    #1 chk("waw_wb_release", 32'(stall), 32'd0);
    tick();
    idle();
    #1;
    chk("waw_busy_kept", busy, 32'h0000_0200);
    chk("waw_pend", 32'(pend_cnt), 32'd1);
    issue_long(0);
    chk("x0_busy", busy, 32'h0000_0200);
    chk("x0_pend", 32'(pend_cnt), 32'd2);

    // unused sources and invalid ID
    do_reset();
    issue_long(6);
    id_valid = 1; rs1 = 3; rs1_used = 1; rs2 = 6; rs2_used = 0;
    #1 chk("unused_rs2", 32'(stall), 32'd0);
    rs2_used = 1;
    #1 chk("used_rs2", 32'(stall), 32'd1);
    id_valid = 0;
    #1 chk("invalid_raw", 32'(stall), 32'd0);
    rs1 = 4; wb_sel_frm_ex = 2'b01; rd_frm_ex = 4;
    #1 chk("invalid_lu", 32'(stall), 32'd0);

    // reset under a live hazard
    idle();
    issue_long(11);
    issue_long(12);
    chk("pre_rst_pend", 32'(pend_cnt), 32'd3);
    id_valid = 1; rs1 = 6; rs1_used = 1;
    #1 chk("pre_rst_stall", 32'(stall), 32'd1);
    rst = 1;
    #1;
    chk("in_rst_stall", 32'(stall), 32'd0);
    chk("in_rst_flush", 32'(flush), 32'd0);
    tick();
    chk("post_rst_busy", busy, 32'h0);
    chk("post_rst_pend", 32'(pend_cnt), 32'd0);
    chk("post_rst_scnt", 32'(stall_cycles), 32'd0);
    rst = 0;
    #1 chk("post_rst_nohaz", 32'(stall), 32'd0);

    // stall counter saturation (4-bit counter)
    idle();
    issue_long(8);
    id_valid = 1; rs2 = 8; rs2_used = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_scnt", 32'(stall_cycles), 32'd15);
    lwb_valid = 1; lwb_rd = 8;
    tick();
    idle();
    #1;
    chk("sat_pend", 32'(pend_cnt), 32'd0);
    chk("sat_scnt_hold", 32'(stall_cycles), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
